// File: rtl/clk_period_meter.sv
// Clock period / high-time meter.
// Measures i_meas_clk in i_clk cycles between synchronized rising edges.
module clk_period_meter #(
  parameter int P_CNT_WIDTH = 16,
  parameter int P_TIMEOUT   = 65535
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_meas_clk,
  input  logic                   i_en,
  output logic [P_CNT_WIDTH-1:0] o_period,
  output logic [P_CNT_WIDTH-1:0] o_high,
  output logic                   o_valid,
  output logic                   o_timeout
);

  localparam logic [P_CNT_WIDTH-1:0] TMO = P_CNT_WIDTH'(P_TIMEOUT);
  localparam logic [P_CNT_WIDTH-1:0] ONE = P_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t                 state;
  logic                   sync1;
  logic                   sync2;
  logic                   hist;
  logic                   rise_det;
  logic [P_CNT_WIDTH-1:0] per_cnt;
  logic [P_CNT_WIDTH-1:0] high_cnt;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= i_meas_clk;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise_det = sync2 & ~hist;

  // Measurement FSM; counters and outputs all registered here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      per_cnt   <= '0;
      high_cnt  <= '0;
      o_period  <= '0;
      o_high    <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!i_en) begin
        state    <= IDLE;
        per_cnt  <= '0;
        high_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= ARM;
          end
          ARM: begin
            if (rise_det) begin
              state    <= MEASURE;
              per_cnt  <= ONE;
              high_cnt <= ONE;
            end
          end
          MEASURE: begin
            if (rise_det) begin
              o_period  <= per_cnt;
              o_high    <= high_cnt;
              o_valid   <= 1'b1;
              o_timeout <= 1'b0;
              per_cnt   <= ONE;
              high_cnt  <= ONE;
            end else if (per_cnt == TMO) begin
              o_timeout <= 1'b1;
              state     <= ARM;
              per_cnt   <= '0;
              high_cnt  <= '0;
            end else begin
              per_cnt <= per_cnt + ONE;
              if (sync2) begin
                high_cnt <= high_cnt + ONE;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter.
// Measured clock is generated on i_clk falling edges from a phase counter.
module tb_clk_period_meter;

  localparam int W   = 16;
  localparam int TMO = 20;

  typedef struct {
    int per;
    int hi;
    int n;
    int exp_p;
    int exp_h;
    int exp_v;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         meas;
  logic         en;
  logic [W-1:0] period;
  logic [W-1:0] high;
  logic         valid;
  logic         timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vcnt  = 0;
  int last_vcyc = 0;
  int to_cyc = -1;
  int gen_on = 0;
  int gen_per = 4;
  int gen_hi = 2;
  int phase = 0;
  int exp_p = 0;
  int exp_h = 0;
  int v0;

  vec_t tbl [6];

  always #5 clk = ~clk;

  clk_period_meter #(
    .P_CNT_WIDTH(W),
    .P_TIMEOUT  (TMO)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_meas_clk(meas),
    .i_en      (en),
    .o_period  (period),
    .o_high    (high),
    .o_valid   (valid),
    .o_timeout (timeout)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // One i_clk cycle: sample outputs on the falling edge, then drive meas.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (valid) begin
      vcnt++;
      last_vcyc = cyc;
      check("valid_period", int'(period), exp_p);
      check("valid_high", int'(high), exp_h);
    end
    if (timeout && to_cyc < 0) to_cyc = cyc;
    if (gen_on != 0) begin
      meas  = (phase < gen_hi);
      phase = (phase + 1 == gen_per) ? 0 : phase + 1;
    end else begin
      meas  = 1'b0;
      phase = 0;
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    en     = 1'b0;
    gen_on = 0;
    tick();
    tick();
    rst    = 1'b0;
    to_cyc = -1;
  endtask

  task automatic wait_valid(input string name);
    int start;
    int k;
    start = vcnt;
    k = 0;
    while (vcnt == start && k < 60) begin
      tick();
      k++;
    end
    check(name, int'(vcnt != start), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_high"}, int'(high), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    tbl[0] = '{4, 2, 5, 4, 2, 4};
    tbl[1] = '{10, 3, 4, 10, 3, 3};
    tbl[2] = '{7, 5, 3, 7, 5, 2};
    tbl[3] = '{5, 1, 4, 5, 1, 3};
    tbl[4] = '{20, 10, 3, 20, 10, 2};
    tbl[5] = '{8, 4, 4, 8, 4, 3};

    rst  = 1'b1;
    en   = 1'b0;
    meas = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;

    // Table: steady clocks, then stop and expect timeout 20 cycles later.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      exp_p   = tbl[i].exp_p;
      exp_h   = tbl[i].exp_h;
      gen_per = tbl[i].per;
      gen_hi  = tbl[i].hi;
      en      = 1'b1;
      tick();
      tick();
      vcnt   = 0;
      gen_on = 1;
      repeat (tbl[i].per * tbl[i].n) tick();
      gen_on = 0;
      repeat (40) tick();
      check("vec_valid_count", vcnt, tbl[i].exp_v);
      check("vec_timeout_delay", to_cyc - last_vcyc, TMO);
      check("vec_period_hold", int'(period), tbl[i].exp_p);
      check("vec_high_hold", int'(high), tbl[i].exp_h);
      check("vec_timeout", int'(timeout), 1);
    end

    // Resume after timeout: first edge silent, second clears timeout.
    v0     = vcnt;
    gen_on = 1;
    repeat (10) tick();
    check("resume_silent", vcnt, v0);
    check("resume_to_held", int'(timeout), 1);
    repeat (4) tick();
    check("resume_report", vcnt, v0 + 1);
    check("resume_to_clr", int'(timeout), 0);
    gen_on = 0;

    // Enable dropped mid-period for 5 cycles.
    do_reset();
    exp_p   = 10;
    exp_h   = 3;
    gen_per = 10;
    gen_hi  = 3;
    en      = 1'b1;
    tick();
    gen_on = 1;
    wait_valid("endrop_first");
    tick();
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    v0 = vcnt;
    repeat (12) tick();
    check("endrop_silent", vcnt, v0);
    repeat (6) tick();
    check("endrop_report", vcnt, v0 + 1);

    // Enable falls in the same cycle as rise_det.
    wait_valid("encoinc_sync");
    repeat (9) tick();
    en = 1'b0;
    v0 = vcnt;
    repeat (4) tick();
    check("encoinc_no_valid", vcnt, v0);
    check("encoinc_period", int'(period), 10);

    // Reset pulsed mid-measurement, period 12.
    gen_on = 0;
    do_reset();
    exp_p   = 12;
    exp_h   = 6;
    gen_per = 12;
    gen_hi  = 6;
    en      = 1'b1;
    tick();
    gen_on = 1;
    wait_valid("rstmid_first");
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_zero("rstmid");
    tick();
    tick();
    rst = 1'b0;
    v0  = vcnt;
    repeat (12) tick();
    check("rstmid_silent", vcnt, v0);
    repeat (7) tick();
    check("rstmid_report", vcnt, v0 + 1);
    check("rstmid_period", int'(period), 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
